// File: rtl/alu_nibble_sequencer_if.sv
// alu_nibble_sequencer_if: request/result bus plus 4-bit ALU core bus of the nibble sequencer.
// Under ALU_SEQ_ABORT_EN the bus also carries the abort request.
interface alu_nibble_sequencer_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         sign;
  logic [3:0]   alu_sel;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic         alu_ci;
  logic [3:0]   alu_r;
  logic         alu_co;
  logic         alu_ov;
`ifdef ALU_SEQ_ABORT_EN
  logic         abort;
  modport master (output start, op, opa, opb, cin, abort, alu_r, alu_co, alu_ov,
                  input  busy, done, result, cout, ovf, zero, sign, alu_sel, alu_a, alu_b, alu_ci);
  modport slave  (input  start, op, opa, opb, cin, abort, alu_r, alu_co, alu_ov,
                  output busy, done, result, cout, ovf, zero, sign, alu_sel, alu_a, alu_b, alu_ci);
`else
  modport master (output start, op, opa, opb, cin, alu_r, alu_co, alu_ov,
                  input  busy, done, result, cout, ovf, zero, sign, alu_sel, alu_a, alu_b, alu_ci);
  modport slave  (input  start, op, opa, opb, cin, alu_r, alu_co, alu_ov,
                  output busy, done, result, cout, ovf, zero, sign, alu_sel, alu_a, alu_b, alu_ci);
`endif
endinterface

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs W-bit ops on a shared 4-bit ALU core, one nibble per clock, LSB first.
// Optional ALU_SEQ_ABORT_EN adds an abort request that drops a running operation without DONE.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input logic clk,
  input logic rst_n,
  alu_nibble_sequencer_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    op_q, op_d;
  logic [W-1:0]  opa_q, opa_d, opb_q, opb_d, acc_q, acc_d, result_q, result_d;
  logic          cin_q, cin_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic          run, last, abort;
  assign run  = state_q == RUN;
  assign last = k_q == KW'(NIBBLES - 1);
`ifdef ALU_SEQ_ABORT_EN
  assign abort = bus.abort;
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end
  // The word result is published as the last nibble lands, so it is valid while DONE is high.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cin_d    = cin_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (state_q == IDLE && bus.start) begin
      state_d = RUN;
      k_d     = '0;
      op_d    = bus.op;
      opa_d   = bus.opa;
      opb_d   = bus.opb;
      cin_d   = bus.cin;
    end else if (run && abort) begin
      state_d = IDLE;
    end else if (run) begin
      acc_d[4*k_q +: 4] = bus.alu_r;
      carry_d = bus.alu_co;
      k_d     = k_q + 1'b1;
      if (last) begin
        state_d  = FIN;
        cout_d   = bus.alu_co;
        ovf_d    = bus.alu_ov;
        result_d = acc_d;
      end
    end else if (state_q == FIN) begin
      state_d = IDLE;
    end
  end
  // ADD/SUB switch to their carry-chaining core variants above nibble 0.
  always_comb begin
    bus.alu_a   = run ? opa_q[4*k_q +: 4] : 4'd0;
    bus.alu_b   = run ? opb_q[4*k_q +: 4] : 4'd0;
    bus.alu_sel = !run ? 4'd0 : (!op_q[2] && !op_q[1] && k_q != '0) ? {op_q[3], 2'b01, op_q[0]} : op_q;
    bus.alu_ci  = !run || op_q[2] ? 1'b0 : k_q != '0 ? carry_q : op_q[1] & cin_q;
  end
  assign bus.busy   = state_q != IDLE;
  assign bus.done   = state_q == FIN;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = result_q == '0;
  assign bus.sign   = result_q[W-1] ^ ovf_q;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: random and directed ops against a word-level reference model;
// a monitor pops the scoreboard on every DONE. Abort tests run when ALU_SEQ_ABORT_EN is defined.
module tb_alu_nibble_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;
  typedef struct packed {logic [W-1:0] r; logic c; logic v;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  alu_nibble_sequencer_if #(.NIBBLES(N)) bus();
  alu_nibble_sequencer #(.NIBBLES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // 4-bit ALU core stand-in: returns {ov, co, r}
  function automatic logic [5:0] core(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b, input logic ci);
    int ua, ub, sa, sbb, ic, t, s;
    logic [3:0] r;
    logic co, ov;
    ua = int'(a); ub = int'(b); sa = int'($signed(a)); sbb = int'($signed(b)); ic = int'(ci);
    t = 0; s = 0; r = 4'd0; co = 1'b0; ov = 1'b0;
    case (sel[2:0])
      3'd0: begin t = ua + ub;      s = sa + sbb;      end
      3'd1: begin t = ua - ub;      s = sa - sbb;      end
      3'd2: begin t = ua + ub + ic; s = sa + sbb + ic; end
      3'd3: begin t = ua - ub - ic; s = sa - sbb - ic; end
      3'd4: r = sel[3] ? ~(a & b) : a & b;
      3'd5: r = sel[3] ? ~(a | b) : a | b;
      3'd6: r = sel[3] ? ~(a ^ b) : a ^ b;
      default: begin r = ~b; co = 1'b1; end
    endcase
    if (!sel[2]) begin
      r  = 4'(t);
      co = t < 0 || t > 15;
      ov = s < -8 || s > 7;
    end
    return {ov, co, r};
  endfunction

  always_comb {bus.alu_ov, bus.alu_co, bus.alu_r} = core(bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_ci);

  // word-level reference: whole-operand arithmetic, no nibble slicing
  function automatic exp_t ref_word(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    longint ua, ub, sa, sbb, ic, t, s, maxu, smax;
    exp_t e;
    ua = longint'(a); ub = longint'(b); sa = longint'($signed(a)); sbb = longint'($signed(b)); ic = longint'(ci);
    maxu = (longint'(1) << W) - 1;
    smax = (longint'(1) << (W - 1)) - 1;
    t = 0; s = 0; e = '0;
    case (op[2:0])
      3'd0: begin t = ua + ub;      s = sa + sbb;      end
      3'd1: begin t = ua - ub;      s = sa - sbb;      end
      3'd2: begin t = ua + ub + ic; s = sa + sbb + ic; end
      3'd3: begin t = ua - ub - ic; s = sa - sbb - ic; end
      3'd4: e.r = op[3] ? ~(a & b) : a & b;
      3'd5: e.r = op[3] ? ~(a | b) : a | b;
      3'd6: e.r = op[3] ? ~(a ^ b) : a ^ b;
      default: begin e.r = ~b; e.c = 1'b1; end
    endcase
    if (!op[2]) begin
      e.r = W'(t);
      e.c = t < 0 || t > maxu;
      e.v = s > smax || s < -smax - 1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 result=%h", bus.result);
        end else begin
          e = sb.pop_front();
          chk("sb_result", bus.result, e.r);
          chk("sb_cout", W'(bus.cout), W'(e.c));
          chk("sb_ovf", W'(bus.ovf), W'(e.v));
          chk("sb_zero", W'(bus.zero), W'(e.r == '0));
          chk("sb_sign", W'(bus.sign), W'(e.r[W-1] ^ e.v));
        end
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input bit adc_chk, input bit glitch);
    int cnt, busy_n;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.opa = a; bus.opb = b; bus.cin = ci;
    sb.push_back(ref_word(op, a, b, ci));
    @(posedge clk); #1;
    bus.start = 1'b0;
    cnt = 0;
    busy_n = 0;
    while (!bus.done && cnt < 20) begin
      if (bus.busy) busy_n++;
      if (adc_chk) begin
        chk("adc_sel", W'(bus.alu_sel), W'({op[3], 3'b010}));
        chk("adc_ci", W'(bus.alu_ci), W'(1'b1));
      end
      if (glitch && cnt == 1) begin
        bus.start = 1'b1; bus.op = ~op; bus.opa = W'($urandom); bus.opb = W'($urandom); bus.cin = ~ci;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cnt++;
    end
    if (bus.busy) busy_n++;
    chk("done_latency", W'(cnt), W'(N));
    chk("busy_cycles", W'(busy_n), W'(N + 1));
  endtask

  task automatic now3(input string name, input logic [W-1:0] r, input logic c, input logic v);
    chk({name, "_result"}, bus.result, r);
    chk({name, "_cout"}, W'(bus.cout), W'(c));
    chk({name, "_ovf"}, W'(bus.ovf), W'(v));
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 4'd0; bus.opa = '0; bus.opb = '0; bus.cin = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    #2;
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_result", bus.result, '0);
    chk("rst_flags", W'({bus.cout, bus.ovf, bus.zero, bus.sign}), W'(4'b0010));
    chk("rst_alu", W'({bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_ci}), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(4'b0000, 16'h00FF, 16'h0001, 1'b0, 0, 0);
    now3("tp1", 16'h0100, 1'b0, 1'b0);
    chk("tp1_zero", W'(bus.zero), '0);
    run_op(4'b0000, 16'h7FFF, 16'h0001, 1'b0, 0, 0);
    now3("tp2a", 16'h8000, 1'b0, 1'b1);
    chk("tp2a_sign", W'(bus.sign), '0);
    run_op(4'b0000, 16'hFFFF, 16'h0001, 1'b0, 0, 0);
    now3("tp2b", 16'h0000, 1'b1, 1'b0);
    chk("tp2b_zero", W'(bus.zero), W'(1'b1));
    run_op(4'b0001, 16'h0000, 16'h0001, 1'b0, 0, 0);
    now3("tp3a", 16'hFFFF, 1'b1, 1'b0);
    chk("tp3a_sign", W'(bus.sign), W'(1'b1));
    run_op(4'b0011, 16'h0005, 16'h0003, 1'b1, 0, 0);
    now3("tp3b", 16'h0001, 1'b0, 1'b0);
    run_op(4'b0010, 16'hFFFF, 16'h0000, 1'b1, 1, 0);
    now3("tp4", 16'h0000, 1'b1, 1'b0);
    run_op(4'b0111, 16'h5A5A, 16'h1234, 1'b0, 0, 0);
    now3("tp5a", 16'hEDCB, 1'b1, 1'b0);
    run_op(4'b1110, 16'hA5A5, 16'hA5A5, 1'b0, 0, 0);
    chk("tp5b_result", bus.result, 16'hFFFF);
    run_op(4'b0100, 16'hF0F0, 16'h0FF0, 1'b0, 0, 0);
    now3("tp5c", 16'h00F0, 1'b0, 1'b0);

    run_op(4'b0000, 16'h1234, 16'h1111, 1'b0, 0, 1);
    now3("glitch", 16'h2345, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("glitch_idle", W'(bus.busy), '0);

    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 4'b0000; bus.opa = 16'h4444; bus.opb = 16'h1111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstrun_busy", W'(bus.busy), '0);
    chk("rstrun_result", bus.result, '0);
    chk("rstrun_done", W'(bus.done), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    run_op(4'b0000, 16'h1111, 16'h2222, 1'b0, 0, 0);
    now3("after_rst", 16'h3333, 1'b0, 1'b0);

`ifdef ALU_SEQ_ABORT_EN
    run_op(4'b0000, 16'h0F0F, 16'h0101, 1'b0, 0, 0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 4'b0001; bus.opa = 16'h0000; bus.opb = 16'h0001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_busy", W'(bus.busy), '0);
    repeat (6) @(posedge clk);
    #1 now3("abort_keep", 16'h1010, 1'b0, 1'b0);
`endif

    repeat (200) run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 0, 0);

    repeat (4) @(posedge clk);
    chk("sb_empty", W'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
